// File: rtl/stroke_if.sv
// -----------------------------------------------------------------------------
// stroke_if
// Bundles every signal around the stroke sequencer apart from clk/rst:
//   - start/abort/sel handshake from the character/menu FSM
//   - segment-table lookup (seg_idx/sel_q out, pen/last/coordinates back)
//   - line-stepper control (ln_rst/ln_en out, ln_done back)
//   - servo command and status (pen_down, busy, done, overrun, state)
// Modports:
//   slave   : the stroke sequencer itself
//   master  : the surrounding environment (controller FSM + segment table)
//   stepper : the line stepper, which reads the segment coordinates directly
// -----------------------------------------------------------------------------
interface stroke_if #(
   parameter int COORD_W = 8,
   parameter int IDX_W   = 5
);
   logic               start;
   logic               abort;
   logic [3:0]         sel;
   logic [IDX_W-1:0]   seg_idx;
   logic               seg_pen;
   logic               seg_last;
   logic [COORD_W-1:0] seg_sx;
   logic [COORD_W-1:0] seg_sy;
   logic [COORD_W-1:0] seg_ex;
   logic [COORD_W-1:0] seg_ey;
   logic [3:0]         sel_q;
   logic               ln_rst;
   logic               ln_en;
   logic               ln_done;
   logic               pen_down;
   logic               busy;
   logic               done;
   logic               overrun;
   logic [2:0]         state;

   modport slave (
      input  start, abort, sel, seg_pen, seg_last, ln_done,
      output seg_idx, sel_q, ln_rst, ln_en, pen_down, busy, done, overrun, state
   );

   modport master (
      output start, abort, sel, seg_pen, seg_last, seg_sx, seg_sy, seg_ex, seg_ey, ln_done,
      input  seg_idx, sel_q, ln_rst, ln_en, pen_down, busy, done, overrun, state
   );

   modport stepper (
      input  seg_sx, seg_sy, seg_ex, seg_ey, ln_rst, ln_en,
      output ln_done
   );
endinterface

// File: rtl/stroke_sequencer.sv
// -----------------------------------------------------------------------------
// stroke_sequencer
// Walks a glyph segment table, commands the pen servo with a settle delay and
// hands each segment to the line stepper (reset/arm hold, then enable until
// the stepper reports done). Settling is skipped when the pen is already in
// the requested position. Running off the end of the table without a
// seg_last marker sets the sticky overrun flag instead of wrapping.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : stroke_if.slave (handshake, table lookup, stepper control, status)
// IDX_W must match the IDX_W of the connected stroke_if.
// -----------------------------------------------------------------------------
module stroke_sequencer #(
   parameter int IDX_W      = 5,
   parameter int SETTLE_CYC = 200000000,
   parameter int ARM_CYC    = 600000
) (
   input  logic     clk,
   input  logic     rst,
   stroke_if.slave  bus
);

   localparam int CNT_MAX = (SETTLE_CYC > ARM_CYC) ? SETTLE_CYC : ARM_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Settle: entry cycle updates the servo, then SETTLE_CYC cycles pass with
   // the new pen position before moving on (counter runs 1..SETTLE_CYC).
   localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC);
   // Arm: ARM_CYC cycles total (counter runs 0..ARM_CYC-1).
   localparam logic [CNT_W-1:0] ARM_END    = CNT_W'(ARM_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = '1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PEN  = 3'd1,
      S_ARM  = 3'd2,
      S_MOVE = 3'd3,
      S_LIFT = 3'd4,
      S_DONE = 3'd5
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] seg_idx_q;
   logic [3:0]       sel_q;
   logic             pen_q;
   logic             overrun_q;

   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all of them update from the
      // values present before the edge, independent of statement order.
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         seg_idx_q <= '0;
         sel_q     <= '0;
         pen_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               // abort takes priority over a simultaneous start in DONE
               if (state_q == S_DONE && bus.abort) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (bus.start) begin
                  sel_q     <= bus.sel;
                  seg_idx_q <= '0;
                  overrun_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= S_PEN;
               end
            end

            S_PEN: begin
               if (bus.abort) begin
                  cnt_q   <= '0;
                  state_q <= S_LIFT;
               end else if (cnt_q == '0) begin
                  pen_q <= bus.seg_pen;
                  if (bus.seg_pen == pen_q) begin
                     state_q <= S_ARM;   // pen already in place: no settle
                  end else begin
                     cnt_q <= CNT_W'(1);
                  end
               end else if (cnt_q == SETTLE_END) begin
                  cnt_q   <= '0;
                  state_q <= S_ARM;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_ARM: begin
               if (bus.abort) begin
                  cnt_q   <= '0;
                  state_q <= S_LIFT;
               end else if (cnt_q == ARM_END) begin
                  cnt_q   <= '0;
                  state_q <= S_MOVE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_MOVE: begin
               if (bus.abort) begin
                  cnt_q   <= '0;
                  state_q <= S_LIFT;
               end else if (bus.ln_done) begin
                  cnt_q <= '0;
                  if (bus.seg_last) begin
                     state_q <= S_LIFT;
                  end else if (seg_idx_q == IDX_LAST) begin
                     // table exhausted without an end marker: stop, never wrap
                     overrun_q <= 1'b1;
                     state_q   <= S_LIFT;
                  end else begin
                     seg_idx_q <= seg_idx_q + 1'b1;
                     state_q   <= S_PEN;
                  end
               end
            end

            S_LIFT: begin
               // abort is deliberately ignored here: the pen is already lifting
               if (cnt_q == '0) begin
                  pen_q <= 1'b0;
                  if (!pen_q) begin
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= CNT_W'(1);
                  end
               end else if (cnt_q == SETTLE_END) begin
                  cnt_q   <= '0;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Stepper controls and status flags are pure decodes of the state register.
   assign bus.ln_rst   = (state_q == S_ARM);
   assign bus.ln_en    = (state_q == S_ARM) || (state_q == S_MOVE);
   assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.state    = state_q;
   assign bus.seg_idx  = seg_idx_q;
   assign bus.sel_q    = sel_q;
   assign bus.pen_down = pen_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_stroke_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stroke_sequencer
// Directed bench for stroke_sequencer with SETTLE_CYC=4, ARM_CYC=3, IDX_W=3.
// A cycle-by-cycle trace table covers a full three-segment glyph; short
// hand-written sequences cover overrun, abort, busy-start, mid-stroke reset
// and restart from DONE. The segment table is modelled combinationally from
// pen_tab/last_idx/has_last.
// -----------------------------------------------------------------------------
module tb_stroke_sequencer;

   localparam int COORD_W = 8;
   localparam int IDX_W   = 3;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PEN  = 3'd1;
   localparam logic [2:0] ST_ARM  = 3'd2;
   localparam logic [2:0] ST_MOVE = 3'd3;
   localparam logic [2:0] ST_LIFT = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   logic clk;
   logic rst;

   stroke_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) bus ();

   stroke_sequencer #(
      .IDX_W      (IDX_W),
      .SETTLE_CYC (4),
      .ARM_CYC    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Segment table model
   logic [7:0] pen_tab;
   logic [2:0] last_idx;
   logic       has_last;

   assign bus.seg_pen  = pen_tab[bus.seg_idx];
   assign bus.seg_last = has_last && (bus.seg_idx == last_idx);
   assign bus.seg_sx   = {bus.sel_q, 1'b0, bus.seg_idx};
   assign bus.seg_sy   = {bus.sel_q, 1'b1, bus.seg_idx};
   assign bus.seg_ex   = {bus.seg_idx, 1'b0, bus.sel_q};
   assign bus.seg_ey   = {bus.seg_idx, 1'b1, bus.sel_q};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output bundle
   typedef struct packed {
      logic [2:0] st;
      logic       pen;
      logic       lrst;
      logic       len;
      logic [2:0] idx;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      logic start;
      logic abort;
      logic ln_done;
      obs_t exp;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tr[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.st   = bus.state;
      o.pen  = bus.pen_down;
      o.lrst = bus.ln_rst;
      o.len  = bus.ln_en;
      o.idx  = bus.seg_idx;
      o.busy = bus.busy;
      o.done = bus.done;
      return o;
   endfunction

   // Expected bundle from state/pen/idx; stepper controls and flags follow
   // directly from which state the sequencer is in.
   function automatic obs_t mk_obs(input logic [2:0] st, input logic pen, input logic [2:0] idx);
      obs_t o;
      o.st   = st;
      o.pen  = pen;
      o.lrst = (st == ST_ARM);
      o.len  = (st == ST_ARM) || (st == ST_MOVE);
      o.idx  = idx;
      o.busy = !((st == ST_IDLE) || (st == ST_DONE));
      o.done = (st == ST_DONE);
      return o;
   endfunction

   function automatic vec_t mk(input logic s, input logic a, input logic d,
                               input logic [2:0] st, input logic pen, input logic [2:0] idx);
      vec_t v;
      v.start   = s;
      v.abort   = a;
      v.ln_done = d;
      v.exp     = mk_obs(st, pen, idx);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] tgt, input string name);
      int n = 0;
      while (bus.state !== tgt && n < 100) begin
         step();
         n++;
      end
      check(name, 32'(bus.state), 32'(tgt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.sel     = 4'd0;
      bus.ln_done = 1'b0;
      pen_tab     = 8'b0000_0011;   // idx0=1, idx1=1, idx2=0
      last_idx    = 3'd2;
      has_last    = 1'b1;

      // ---------------- reset state
      step();
      step();
      check("reset_obs",     32'(sample()), 32'(mk_obs(ST_IDLE, 1'b0, 3'd0)));
      check("reset_sel_q",   32'(bus.sel_q), 32'd0);
      check("reset_overrun", 32'(bus.overrun), 32'd0);
      rst = 1'b0;
      step();
      check("idle_obs", 32'(sample()), 32'(mk_obs(ST_IDLE, 1'b0, 3'd0)));

      // ---------------- trace: three-segment glyph, pen {1,1,0}, last at idx2
      tr.push_back(mk(1, 0, 0, ST_PEN,  1'b0, 3'd0));   // accept
      tr.push_back(mk(0, 0, 0, ST_PEN,  1'b1, 3'd0));   // pen goes down
      for (int i = 0; i < 3; i++) tr.push_back(mk(0, 0, 0, ST_PEN, 1'b1, 3'd0));
      for (int i = 0; i < 3; i++) tr.push_back(mk(0, 0, 0, ST_ARM, 1'b1, 3'd0));
      tr.push_back(mk(0, 0, 0, ST_MOVE, 1'b1, 3'd0));
      tr.push_back(mk(0, 0, 0, ST_MOVE, 1'b1, 3'd0));   // stepper still busy
      tr.push_back(mk(0, 0, 1, ST_PEN,  1'b1, 3'd1));   // seg0 done
      for (int i = 0; i < 3; i++) tr.push_back(mk(0, 0, 0, ST_ARM, 1'b1, 3'd1)); // no settle
      tr.push_back(mk(0, 0, 0, ST_MOVE, 1'b1, 3'd1));
      tr.push_back(mk(0, 0, 1, ST_PEN,  1'b1, 3'd2));   // seg1 done
      tr.push_back(mk(0, 0, 0, ST_PEN,  1'b0, 3'd2));   // pen lifts for seg2
      for (int i = 0; i < 3; i++) tr.push_back(mk(0, 0, 0, ST_PEN, 1'b0, 3'd2));
      for (int i = 0; i < 3; i++) tr.push_back(mk(0, 0, 0, ST_ARM, 1'b0, 3'd2));
      tr.push_back(mk(0, 0, 0, ST_MOVE, 1'b0, 3'd2));
      tr.push_back(mk(0, 0, 1, ST_LIFT, 1'b0, 3'd2));   // last segment
      tr.push_back(mk(0, 0, 0, ST_DONE, 1'b0, 3'd2));   // already up: no settle
      tr.push_back(mk(0, 0, 0, ST_DONE, 1'b0, 3'd2));   // holds

      bus.sel = 4'd2;
      foreach (tr[i]) begin
         bus.start   = tr[i].start;
         bus.abort   = tr[i].abort;
         bus.ln_done = tr[i].ln_done;
         step();
         check($sformatf("trace[%0d]", i), 32'(sample()), 32'(tr[i].exp));
      end
      bus.start   = 1'b0;
      bus.ln_done = 1'b0;
      check("trace_sel_q",   32'(bus.sel_q), 32'd2);
      check("trace_overrun", 32'(bus.overrun), 32'd0);

      // ---------------- overrun: no end marker in 8 entries, pen always up
      pen_tab     = 8'h00;
      has_last    = 1'b0;
      bus.ln_done = 1'b1;
      bus.sel     = 4'd7;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      check("ovr_started", 32'(bus.state), 32'(ST_PEN));
      wait_state(ST_DONE, "ovr_reach_done");
      check("ovr_flag", 32'(bus.overrun), 32'd1);
      check("ovr_idx",  32'(bus.seg_idx), 32'd7);
      check("ovr_obs",  32'(sample()), 32'(mk_obs(ST_DONE, 1'b0, 3'd7)));
      bus.ln_done = 1'b0;

      // ---------------- restart from DONE clears overrun and latches sel
      bus.sel   = 4'd5;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("restart_sel_q",   32'(bus.sel_q), 32'd5);
      check("restart_idx",     32'(bus.seg_idx), 32'd0);
      check("restart_overrun", 32'(bus.overrun), 32'd0);
      check("restart_state",   32'(bus.state), 32'(ST_PEN));
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("restart_abort_lift", 32'(bus.state), 32'(ST_LIFT));
      step();
      check("restart_abort_done", 32'(bus.state), 32'(ST_DONE));

      // ---------------- abort mid-MOVE at idx1
      pen_tab  = 8'b0000_0011;
      has_last = 1'b1;
      last_idx = 3'd2;
      bus.sel  = 4'd2;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_state(ST_MOVE, "abort_move0");
      bus.ln_done = 1'b1;
      step();
      bus.ln_done = 1'b0;
      wait_state(ST_MOVE, "abort_move1");
      check("abort_at_idx1", 32'(bus.seg_idx), 32'd1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_lift_obs", 32'(sample()), 32'(mk_obs(ST_LIFT, 1'b1, 3'd1)));
      step();
      check("abort_pen_up", 32'(sample()), 32'(mk_obs(ST_LIFT, 1'b0, 3'd1)));
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("abort_settle[%0d]", i), 32'(bus.state), 32'(ST_LIFT));
      end
      step();
      check("abort_done", 32'(sample()), 32'(mk_obs(ST_DONE, 1'b0, 3'd1)));
      bus.sel   = 4'd9;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("abort_beats_start", 32'(bus.state), 32'(ST_IDLE));
      check("abort_beats_sel",   32'(bus.sel_q), 32'd2);

      // ---------------- start while busy ignored; reset in ARM
      bus.sel   = 4'd3;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("busy_accept", 32'(bus.sel_q), 32'd3);
      bus.sel   = 4'd9;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("busy_ignored_sel", 32'(bus.sel_q), 32'd3);
      check("busy_ignored_obs", 32'(sample()), 32'(mk_obs(ST_PEN, 1'b1, 3'd0)));
      wait_state(ST_ARM, "rst_reach_arm");
      check("rst_pre_pen", 32'(bus.pen_down), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_obs",     32'(sample()), 32'(mk_obs(ST_IDLE, 1'b0, 3'd0)));
      check("rst_sel_q",   32'(bus.sel_q), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
